count_sequencer: RTL and testbench

Control block that sequences an 8-bit synchronous up-counter datapath: start/stop/hold control, a programmable prescaler, and a programmable terminal count.
- Drives the counter value, a per-increment enable tick, a busy flag and a one-cycle done pulse.
- Sits between board switches/keys (via synchronisers) and the counter and hex display path.

---
 rtl/count_seq_pkg.sv | 16 +
 rtl/count_sequencer_tick_gen.sv | 42 ++++
 rtl/count_sequencer.sv | 130 +++++++++++++
 tb/tb_count_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/count_seq_pkg.sv
// rtl/count_seq_pkg.sv - shared types and default sizes for the count sequencer
// Purpose: state encoding and default widths used by count_sequencer and tick_gen.
// Ports: none (package).
package count_seq_pkg;

   localparam int COUNT_WIDTH_DEF = 8;
   localparam int PRESCALE_W_DEF  = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/count_sequencer_tick_gen.sv
// rtl/count_sequencer_tick_gen.sv - prescaler that paces count increments
// Purpose: counts enabled cycles and flags every (ps+1)-th one as an increment.
// Ports:
//   clock, reset_n : clock, synchronous active-low reset
//   clear          : synchronously zeroes the prescaler counter
//   run            : advance the prescaler this edge (frozen when low)
//   ps             : prescaler reload value, increment every ps+1 enabled cycles
//   inc            : combinational, this edge is an increment edge
//   tick           : registered one-cycle pulse following each increment edge
module tick_gen
   import count_seq_pkg::*;
#(
   parameter int PRESCALE_W = PRESCALE_W_DEF
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic                  run,
   input  logic [PRESCALE_W-1:0] ps,
   output logic                  inc,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] pcnt;

   assign inc = run && (pcnt == ps);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         pcnt <= '0;
         tick <= 1'b0;
      end else begin
         tick <= inc;
         if (clear) begin
            pcnt <= '0;
         end else if (run) begin
            pcnt <= inc ? '0 : pcnt + PRESCALE_W'(1);
         end
      end
   end

endmodule

// File: rtl/count_sequencer.sv
// rtl/count_sequencer.sv - start/stop/hold sequencer for an up-counter
// Purpose: runs count from 0 to a latched terminal value at a latched prescaled
// rate, with hold (freeze) and stop (abort, count kept).
// Optional macro COUNT_SEQ_AUTORELOAD_EN adds auto_reload: at the terminal
// increment the count wraps to 0, done pulses and the run continues.
// Ports:
//   clock, reset_n     : clock, synchronous active-low reset
//   start, stop, hold  : level controls (start only honoured in IDLE)
//   terminal, prescale : run parameters, latched when start is accepted
//   auto_reload        : (macro only) repeat the run instead of stopping
//   count              : current count
//   tick               : one-cycle pulse per increment
//   busy               : run in progress (RUN or HOLD)
//   done               : one-cycle pulse when terminal is reached
module count_sequencer
   import count_seq_pkg::*;
#(
   parameter int WIDTH      = COUNT_WIDTH_DEF,
   parameter int PRESCALE_W = PRESCALE_W_DEF
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  hold,
   input  logic [WIDTH-1:0]      terminal,
   input  logic [PRESCALE_W-1:0] prescale,
`ifdef COUNT_SEQ_AUTORELOAD_EN
   input  logic                  auto_reload,
`endif
   output logic [WIDTH-1:0]      count,
   output logic                  tick,
   output logic                  busy,
   output logic                  done
);

   state_t                state, state_nxt;
   logic [WIDTH-1:0]      term_r;
   logic [PRESCALE_W-1:0] ps_r;
   logic                  accept;
   logic                  run;
   logic                  inc;
   logic                  last_inc;
   logic                  reload;

   assign accept   = (state == IDLE) && start && !stop;
   // HOLD is just RUN with the prescaler frozen, so the first edge with hold
   // low already advances; exactly one cycle is lost per held edge.
   assign run      = ((state == RUN) || (state == HOLD)) && !stop && !hold;
   // term_r is at least 1 whenever run is high, so the subtraction cannot wrap.
   assign last_inc = inc && (count == term_r - WIDTH'(1));

`ifdef COUNT_SEQ_AUTORELOAD_EN
   logic reload_done;
   assign reload = last_inc && auto_reload;
   assign done   = (state == DONE) || reload_done;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         reload_done <= 1'b0;
      end else begin
         reload_done <= reload;
      end
   end
`else
   assign reload = 1'b0;
   assign done   = (state == DONE);
`endif

   assign busy = (state == RUN) || (state == HOLD);

   tick_gen #(
      .PRESCALE_W (PRESCALE_W)
   ) u_tick_gen (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (accept),
      .run     (run),
      .ps      (ps_r),
      .inc     (inc),
      .tick    (tick)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = (terminal == '0) ? DONE : RUN;
            end
         end
         RUN, HOLD: begin
            if (stop) begin
               state_nxt = IDLE;
            end else if (hold) begin
               state_nxt = HOLD;
            end else if (last_inc && !reload) begin
               state_nxt = DONE;
            end else begin
               state_nxt = RUN;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state  <= IDLE;
         count  <= '0;
         term_r <= '0;
         ps_r   <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            term_r <= terminal;
            ps_r   <= prescale;
            count  <= '0;
         end else if (inc) begin
            count <= reload ? '0 : count + WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_count_sequencer.sv
// tb/tb_count_sequencer.sv - self-checking bench for count_sequencer
module tb_count_sequencer;

   localparam int W  = 8;
   localparam int PW = 8;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          start;
   logic          stop;
   logic          hold;
   logic [W-1:0]  terminal;
   logic [PW-1:0] prescale;
   logic [W-1:0]  count;
   logic          tick;
   logic          busy;
   logic          done;
`ifdef COUNT_SEQ_AUTORELOAD_EN
   logic          auto_reload = 1'b0;
`endif

   always #5 clock = ~clock;

   count_sequencer #(
      .WIDTH      (W),
      .PRESCALE_W (PW)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start),
      .stop        (stop),
      .hold        (hold),
      .terminal    (terminal),
      .prescale    (prescale),
`ifdef COUNT_SEQ_AUTORELOAD_EN
      .auto_reload (auto_reload),
`endif
      .count       (count),
      .tick        (tick),
      .busy        (busy),
      .done        (done)
   );

   // Reference model: a run is "active edges since start"; count is that
   // number divided by the period, ticks fall on multiples of the period.
   int m_count = 0, m_tick = 0, m_busy = 0, m_done = 0;
   int m_term = 0, m_period = 1, m_act = 0;
   bit m_running = 0, m_finishing = 0;

   int passed = 0;
   int total  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic model_edge();
      if (!reset_n) begin
         m_count = 0; m_tick = 0; m_running = 0; m_finishing = 0;
         m_term = 0; m_period = 1; m_act = 0;
      end else if (m_finishing) begin
         m_finishing = 0;
         m_tick = 0;
      end else if (m_running) begin
         if (stop) begin
            m_running = 0;
            m_tick = 0;
         end else if (hold) begin
            m_tick = 0;
         end else begin
            m_act++;
            m_tick  = ((m_act % m_period) == 0) ? 1 : 0;
            m_count = m_act / m_period;
            if (m_count == m_term) begin
               m_running = 0;
               m_finishing = 1;
            end
         end
      end else begin
         m_tick = 0;
         if (start && !stop) begin
            m_term = int'(terminal);
            m_period = int'(prescale) + 1;
            m_act = 0;
            m_count = 0;
            if (m_term == 0) m_finishing = 1;
            else m_running = 1;
         end
      end
      m_busy = m_running ? 1 : 0;
      m_done = m_finishing ? 1 : 0;
   endtask

   task automatic cyc(input string tag);
      model_edge();
      @(posedge clock);
      #1;
      chk({tag, ".count"}, 32'(count), 32'(m_count));
      chk({tag, ".tick"},  32'(tick),  32'(m_tick));
      chk({tag, ".busy"},  32'(busy),  32'(m_busy));
      chk({tag, ".done"},  32'(done),  32'(m_done));
   endtask

   initial begin
      int ticks;
      int e;
      reset_n = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0;
      terminal = '0; prescale = '0;
      cyc("reset"); cyc("reset");
      reset_n = 1'b1;
      cyc("idle");

      // 1: terminal 5, one increment per cycle
      terminal = 8'd5; prescale = 8'd0; start = 1'b1;
      cyc("t1_start");
      start = 1'b0;
      repeat (5) cyc("t1");
      chk("t1_count5", 32'(count), 32'd5);
      chk("t1_done",   32'(done),  32'd1);
      cyc("t1_after");
      chk("t1_busy_low", 32'(busy), 32'd0);

      // 2: prescale 2, latched values must ignore later input changes
      terminal = 8'd3; prescale = 8'd2; start = 1'b1;
      cyc("t2_start");
      start = 1'b0; terminal = 8'd200; prescale = 8'd0;
      ticks = 0;
      repeat (9) begin cyc("t2"); ticks += int'(tick); end
      chk("t2_count_n9", 32'(count), 32'd3);
      chk("t2_ticks",    32'(ticks), 32'd3);
      chk("t2_done",     32'(done),  32'd1);
      cyc("t2_after");

      // 3: hold four cycles at count 4
      terminal = 8'd10; prescale = 8'd1; start = 1'b1;
      cyc("t3_start");
      start = 1'b0; e = 0;
      while (count != 8'd4 && e < 40) begin cyc("t3"); e++; end
      hold = 1'b1;
      repeat (4) begin cyc("t3_hold"); e++; end
      chk("t3_frozen", 32'(count), 32'd4);
      hold = 1'b0;
      while (!done && e < 60) begin cyc("t3"); e++; end
      chk("t3_done_edge", 32'(e), 32'd24);
      cyc("t3_after");

      // 4: stop at 6, count retained, restart clears
      terminal = 8'd10; prescale = 8'd0; start = 1'b1;
      cyc("t4_start");
      start = 1'b0; e = 0;
      while (count != 8'd6 && e < 20) begin cyc("t4"); e++; end
      stop = 1'b1;
      cyc("t4_stop");
      stop = 1'b0;
      chk("t4_kept", 32'(count), 32'd6);
      chk("t4_idle", 32'(busy),  32'd0);
      repeat (2) cyc("t4_idle");
      terminal = 8'd3; start = 1'b1;
      cyc("t4_restart");
      start = 1'b0;
      chk("t4_cleared", 32'(count), 32'd0);
      repeat (4) cyc("t4_run");

      // 5: terminal 0, then start with stop
      terminal = 8'd0; start = 1'b1;
      cyc("t5_zero");
      start = 1'b0;
      chk("t5_done", 32'(done), 32'd1);
      chk("t5_tick", 32'(tick), 32'd0);
      cyc("t5_after");
      start = 1'b1; stop = 1'b1; terminal = 8'd4;
      cyc("t5_startstop");
      chk("t5_nobusy", 32'(busy), 32'd0);
      start = 1'b0; stop = 1'b0;
      cyc("t5_idle");

      // 6: reset mid-run at count 7
      terminal = 8'd10; prescale = 8'd0; start = 1'b1;
      cyc("t6_start");
      start = 1'b0; e = 0;
      while (count != 8'd7 && e < 20) begin cyc("t6"); e++; end
      reset_n = 1'b0;
      cyc("t6_reset");
      chk("t6_count0", 32'(count), 32'd0);
      reset_n = 1'b1;
      cyc("t6_idle");

      // full range
      terminal = 8'd255; prescale = 8'd0; start = 1'b1;
      cyc("full_start");
      start = 1'b0;
      repeat (255) cyc("full");
      chk("full_count255", 32'(count), 32'd255);
      chk("full_done",     32'(done),  32'd1);
      cyc("full_after");

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         reset_n  = ($urandom_range(0, 299) != 0);
         start    = ($urandom_range(0, 3) == 0);
         stop     = ($urandom_range(0, 24) == 0);
         hold     = ($urandom_range(0, 5) == 0);
         terminal = ($urandom_range(0, 39) == 0) ? 8'd255 : 8'($urandom_range(0, 12));
         prescale = 8'($urandom_range(0, 3));
         cyc("rand");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
